// File: rtl/reg_bank.sv
// Four-entry register bank with a LOAD/INC/DEC/CLEAR engine behind a valid/ready handshake.
// Build option: define REG_BANK_SAT_EN to make INC/DEC saturate instead of wrapping.
module reg_bank #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_code,
  input  logic [1:0]       op_dst,
  input  logic [WIDTH-1:0] op_data,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b,
  output logic [WIDTH-1:0] reg_c,
  output logic [WIDTH-1:0] reg_d,
  output logic             commit_valid,
  output logic             flag_zero,
  output logic             flag_carry
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [1:0]     OP_LOAD  = 2'b00;
  localparam logic [1:0]     OP_INC   = 2'b01;
  localparam logic [1:0]     OP_DEC   = 2'b10;
  localparam logic [WIDTH:0] ONE_EXT  = {{WIDTH{1'b0}}, 1'b1};

  state_t           state, state_nx;
  logic             init_done;
  logic [WIDTH-1:0] regs [4];

  logic [1:0]       code_p0;
  logic [1:0]       dst_p0;
  logic [WIDTH-1:0] data_p0;
  logic [WIDTH:0]   res_p1;

  // Result is {carry, value}; carry doubles as the saturation indicator when saturating.
  function automatic logic [WIDTH:0] op_result(input logic [1:0]       code,
                                               input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] data);
    logic [WIDTH:0] ext;
    ext = {1'b0, cur};
    case (code)
      OP_LOAD: op_result = {1'b0, data};
`ifdef REG_BANK_SAT_EN
      OP_INC:  op_result = (&cur) ? {1'b1, cur} : ext + ONE_EXT;
      OP_DEC:  op_result = (~|cur) ? {1'b1, cur} : ext - ONE_EXT;
`else
      OP_INC:  op_result = ext + ONE_EXT;
      OP_DEC:  op_result = ext - ONE_EXT;
`endif
      default: op_result = '0;
    endcase
  endfunction

  // op_ready stays low until the first clock edge after reset is released.
  assign op_ready = init_done && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      init_done <= 1'b0;
    end else begin
      state     <= state_nx;
      init_done <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (op_valid && op_ready) state_nx = EXEC;
      EXEC:    state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0: operation fields captured at the accept edge
  always_ff @(posedge clk) begin
    if ((state == IDLE) && op_valid && op_ready) begin
      code_p0 <= op_code;
      dst_p0  <= op_dst;
      data_p0 <= op_data;
    end
  end

  // Stage p1: result computed against the current destination contents
  always_ff @(posedge clk) begin
    if (state == EXEC) begin
      res_p1 <= op_result(code_p0, regs[dst_p0], data_p0);
    end
  end

  // Commit: write destination, flags and the one-cycle commit pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= RESET_VAL;
      commit_valid <= 1'b0;
      flag_zero    <= 1'b0;
      flag_carry   <= 1'b0;
    end else begin
      commit_valid <= (state == COMMIT);
      if (state == COMMIT) begin
        regs[dst_p0] <= res_p1[WIDTH-1:0];
        flag_zero    <= ~|res_p1[WIDTH-1:0];
        flag_carry   <= res_p1[WIDTH];
      end
    end
  end

  assign reg_a = regs[0];
  assign reg_b = regs[1];
  assign reg_c = regs[2];
  assign reg_d = regs[3];

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed vector table, handshake/reset corner sequences, random ops vs model.
module tb_reg_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       op_valid;
  logic       op_ready;
  logic [1:0] op_code;
  logic [1:0] op_dst;
  logic [7:0] op_data;
  logic [7:0] reg_a, reg_b, reg_c, reg_d;
  logic       commit_valid;
  logic       flag_zero;
  logic       flag_carry;

  int checks = 0;
  int errors = 0;
  int commits = 0;

  int mdl [4];
  int mz;
  int mc;

  typedef struct {
    int code;
    int dst;
    int data;
    int exp_val;
    int exp_z;
    int exp_c;
  } vec_t;

  vec_t vt [6];

  reg_bank #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_code      (op_code),
    .op_dst       (op_dst),
    .op_data      (op_data),
    .reg_a        (reg_a),
    .reg_b        (reg_b),
    .reg_c        (reg_c),
    .reg_d        (reg_d),
    .commit_valid (commit_valid),
    .flag_zero    (flag_zero),
    .flag_carry   (flag_carry)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (commit_valid === 1'b1) commits++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic int get_reg(input int i);
    case (i)
      0: return int'(reg_a);
      1: return int'(reg_b);
      2: return int'(reg_c);
      default: return int'(reg_d);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mdl[i] = 0;
    mz = 0;
    mc = 0;
  endtask

  // Reference behaviour in plain integer arithmetic.
  task automatic model_op(input int code, input int dst, input int data);
    int r;
    r = mdl[dst];
    case (code)
      0: begin r = data; mc = 0; end
      1: begin
        r = r + 1;
`ifdef REG_BANK_SAT_EN
        if (r > 255) begin r = 255; mc = 1; end else mc = 0;
`else
        mc = (r > 255) ? 1 : 0;
        r  = r % 256;
`endif
      end
      2: begin
        r = r - 1;
`ifdef REG_BANK_SAT_EN
        if (r < 0) begin r = 0; mc = 1; end else mc = 0;
`else
        mc = (r < 0) ? 1 : 0;
        if (r < 0) r = r + 256;
`endif
      end
      default: begin r = 0; mc = 0; end
    endcase
    mdl[dst] = r;
    mz = (r == 0) ? 1 : 0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_reg_a"}, int'(reg_a), mdl[0]);
    chk({tag, "_reg_b"}, int'(reg_b), mdl[1]);
    chk({tag, "_reg_c"}, int'(reg_c), mdl[2]);
    chk({tag, "_reg_d"}, int'(reg_d), mdl[3]);
    chk({tag, "_zero"}, int'(flag_zero), mz);
    chk({tag, "_carry"}, int'(flag_carry), mc);
  endtask

  task automatic wait_accept(output bit ok);
    bit rdy;
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      rdy = op_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: actual op_ready 0 required 1 within 10 cycles");
    end
  endtask

  task automatic scramble_inputs();
    op_code = 2'($urandom_range(0, 3));
    op_dst  = 2'($urandom_range(0, 3));
    op_data = 8'($urandom_range(0, 255));
  endtask

  task automatic do_op(input int code, input int dst, input int data);
    bit ok;
    op_code  = 2'(code);
    op_dst   = 2'(dst);
    op_data  = 8'(data);
    op_valid = 1'b1;
    wait_accept(ok);
    #1;
    op_valid = 1'b0;
    scramble_inputs();
    if (ok) begin
      chk("ready_exec", int'(op_ready), 0);
      chk_all("exec_hold");
      @(posedge clk); #1;
      chk("ready_commit", int'(op_ready), 0);
      chk("cv_early", int'(commit_valid), 0);
      chk_all("commit_hold");
      @(posedge clk); #1;
      model_op(code, dst, data);
      chk("cv_pulse", int'(commit_valid), 1);
      chk("ready_idle", int'(op_ready), 1);
      chk_all("post");
      @(posedge clk); #1;
      chk("cv_drop", int'(commit_valid), 0);
    end
  endtask

  initial begin
    int  c0;
    bit  ok;

    vt[0] = '{0, 2, 'hA5, 'hA5, 0, 0};
    vt[1] = '{0, 1, 'hFF, 'hFF, 0, 0};
`ifdef REG_BANK_SAT_EN
    vt[2] = '{1, 1, 'h00, 'hFF, 0, 1};
    vt[3] = '{3, 3, 'h5A, 'h00, 1, 0};
    vt[4] = '{2, 3, 'h00, 'h00, 1, 1};
    vt[5] = '{1, 3, 'h77, 'h01, 0, 0};
`else
    vt[2] = '{1, 1, 'h00, 'h00, 1, 1};
    vt[3] = '{3, 3, 'h5A, 'h00, 1, 0};
    vt[4] = '{2, 3, 'h00, 'hFF, 0, 1};
    vt[5] = '{1, 3, 'h77, 'h00, 1, 1};
`endif

    // Reset with random inputs toggling
    rst_n    = 1'b0;
    op_valid = 1'b0;
    scramble_inputs();
    model_reset();
    repeat (4) begin
      @(posedge clk); #1;
      op_valid = 1'($urandom_range(0, 1));
      scramble_inputs();
    end
    chk_all("reset");
    chk("reset_cv", int'(commit_valid), 0);
    @(negedge clk);
    op_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("ready_before_edge", int'(op_ready), 0);
    @(posedge clk); #1;
    chk("ready_after_release", int'(op_ready), 1);

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      do_op(vt[i].code, vt[i].dst, vt[i].data);
      chk("vec_reg", get_reg(vt[i].dst), vt[i].exp_val);
      chk("vec_zero", int'(flag_zero), vt[i].exp_z);
      chk("vec_carry", int'(flag_carry), vt[i].exp_c);
    end

    // op_valid held with a new op while busy: accepted only back in IDLE
    c0       = commits;
    op_code  = 2'd0;
    op_dst   = 2'd0;
    op_data  = 8'h11;
    op_valid = 1'b1;
    wait_accept(ok);
    #1;
    op_data = 8'h22;
    chk("busy_ready_exec", int'(op_ready), 0);
    @(posedge clk); #1;
    chk("busy_ready_commit", int'(op_ready), 0);
    @(posedge clk); #1;
    model_op(0, 0, 'h11);
    chk("busy_first_val", int'(reg_a), 'h11);
    chk("busy_first_cv", int'(commit_valid), 1);
    @(posedge clk); #1;
    chk("busy_second_accepted", int'(op_ready), 0);
    op_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_op(0, 0, 'h22);
    chk("busy_second_cv", int'(commit_valid), 1);
    chk_all("busy_second");
    repeat (3) @(posedge clk);
    #1;
    chk("busy_commit_count", commits - c0, 2);

    // Reset while an accepted LOAD is in EXEC
    c0       = commits;
    op_code  = 2'd0;
    op_dst   = 2'd0;
    op_data  = 8'h3C;
    op_valid = 1'b1;
    wait_accept(ok);
    #1;
    op_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all("abort_in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_ready_before_edge", int'(op_ready), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_commit", commits - c0, 0);
    chk("abort_ready", int'(op_ready), 1);
    chk_all("abort");

    // Random operations against the model
    for (int k = 0; k < 150; k++) begin
      do_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) begin
        repeat (int'($urandom_range(1, 3))) @(posedge clk);
        #1;
      end
    end
    chk_all("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
